// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter sequencing fixed-latency accesses on the Bridge data bus.
// Optional performance counters are compiled in when ARB_PERF_CNT_EN is defined.
module bus_arbiter #(
    parameter int RD_LAT = 1,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic [AW-1:0] Bus_addr,
    output logic          Bus_we,
    output logic [DW-1:0] Bus_wdata,
    input  logic [DW-1:0] Bus_rdata,
    output logic          busy
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_gnt0,
    output logic [31:0]   perf_gnt1,
    output logic [31:0]   perf_conflict
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    // Round-robin pick: a lone requester wins, a tie goes to the master not served last.
    function automatic logic pick_winner(input logic req0, input logic req1, input logic last);
        logic win;
        if (req0 && req1) begin
            win = ~last;
        end else if (req1) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
        return win;
    endfunction

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_gnt_q, last_gnt_d;
    logic [2:0]    lat_cnt_q, lat_cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          win_s;
    logic          start_s;

    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic          bus_we_q, bus_we_d;
    logic          busy_q, busy_d;
    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;

    assign win_s   = pick_winner(m0_req, m1_req, last_gnt_q);
    assign start_s = (state_q == ST_IDLE) && (m0_req || m1_req);

    // State and latched-transaction registers.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            lat_cnt_q  <= 3'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            lat_cnt_q  <= lat_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Next-state logic; requests seen in RESP wait for the following IDLE cycle.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        lat_cnt_d  = lat_cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    gnt_d      = win_s;
                    last_gnt_d = win_s;
                    lat_cnt_d  = LAT_INIT;
                    state_d    = ST_ACCESS;
                    if (win_s) begin
                        we_d    = m1_we;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                    end else begin
                        we_d    = m0_we;
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (lat_cnt_q == 3'd0) begin
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        bus_addr_d  = '0;
        bus_wdata_d = '0;
        bus_we_d    = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        if (state_d == ST_ACCESS) begin
            bus_addr_d  = addr_d;
            bus_wdata_d = wdata_d;
            bus_we_d    = start_s && we_d;
        end else begin
            bus_we_d = 1'b0;
        end
        if (state_d == ST_RESP) begin
            m0_ack_d = ~gnt_d;
            m1_ack_d = gnt_d;
        end else begin
            m0_ack_d = 1'b0;
            m1_ack_d = 1'b0;
        end
        if ((state_q == ST_ACCESS) && (lat_cnt_q == 3'd0)) begin
            if (gnt_q) begin
                m1_rdata_d = Bus_rdata;
            end else begin
                m0_rdata_d = Bus_rdata;
            end
        end else begin
            m0_rdata_d = m0_rdata_q;
            m1_rdata_d = m1_rdata_q;
        end
    end

    // Output registers; reset aborts any transaction without an ack or a write strobe.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            busy_q      <= busy_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    assign Bus_addr  = bus_addr_q;
    assign Bus_wdata = bus_wdata_q;
    assign Bus_we    = bus_we_q;
    assign busy      = busy_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_gnt0_q;
    logic [31:0] perf_gnt1_q;
    logic [31:0] perf_conflict_q;

    // Grant and contention counters; a conflict is both requests high in any state.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            perf_gnt0_q     <= 32'd0;
            perf_gnt1_q     <= 32'd0;
            perf_conflict_q <= 32'd0;
        end else begin
            if (start_s && !win_s) begin
                perf_gnt0_q <= perf_gnt0_q + 32'd1;
            end else begin
                perf_gnt0_q <= perf_gnt0_q;
            end
            if (start_s && win_s) begin
                perf_gnt1_q <= perf_gnt1_q + 32'd1;
            end else begin
                perf_gnt1_q <= perf_gnt1_q;
            end
            if (m0_req && m1_req) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end else begin
                perf_conflict_q <= perf_conflict_q;
            end
        end
    end

    assign perf_gnt0     = perf_gnt0_q;
    assign perf_gnt1     = perf_gnt1_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized masters
// compared every cycle against a timeline-based reference model.
module tb_bus_arbiter;

    localparam int LAT = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic          cpu_clk;
    logic          cpu_rst_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_ack, m1_ack;
    logic [AW-1:0] Bus_addr;
    logic          Bus_we;
    logic [DW-1:0] Bus_wdata;
    logic [DW-1:0] Bus_rdata;
    logic          busy;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   perf_gnt0, perf_gnt1, perf_conflict;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bus_arbiter #(.RD_LAT(LAT), .AW(AW), .DW(DW)) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .Bus_addr(Bus_addr), .Bus_we(Bus_we), .Bus_wdata(Bus_wdata),
        .Bus_rdata(Bus_rdata), .busy(busy)
`ifdef ARB_PERF_CNT_EN
        , .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_conflict(perf_conflict)
`endif
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction granted at edge S occupies the bus after edges
    // S..S+LAT-1, acks after edge S+LAT, and the next grant can happen at S+LAT+2.
    int            edge_n = 0;
    bit            md_active;
    int            md_start;
    bit            md_m, md_last, md_we;
    logic [AW-1:0] md_addr;
    logic [DW-1:0] md_wdata;
    logic [DW-1:0] md_rd [2];
    int            md_gcnt [2];
    int            md_conf;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_we, e_busy, e_ack0, e_ack1;

    always @(posedge cpu_clk) begin
        edge_n++;
        if (!cpu_rst_n) begin
            md_active = 1'b0; md_last = 1'b1; md_start = 0;
            md_rd[0] = '0; md_rd[1] = '0;
            md_gcnt[0] = 0; md_gcnt[1] = 0; md_conf = 0;
        end else begin
            if (m0_req && m1_req) md_conf++;
            if (md_active) begin
                if (edge_n == md_start + LAT) md_rd[md_m] = Bus_rdata;
                else if (edge_n == md_start + LAT + 1) md_active = 1'b0;
            end else if (m0_req || m1_req) begin
                md_m     = (m0_req && m1_req) ? !md_last : m1_req;
                md_we    = md_m ? m1_we : m0_we;
                md_addr  = md_m ? m1_addr : m0_addr;
                md_wdata = md_m ? m1_wdata : m0_wdata;
                md_start = edge_n; md_active = 1'b1; md_last = md_m;
                md_gcnt[md_m]++;
            end
        end
        e_addr = '0; e_wdata = '0; e_we = 1'b0; e_busy = md_active; e_ack0 = 1'b0; e_ack1 = 1'b0;
        if (md_active && edge_n < md_start + LAT) begin
            e_addr = md_addr; e_wdata = md_wdata; e_we = md_we && (edge_n == md_start);
        end
        if (md_active && edge_n == md_start + LAT) begin
            e_ack0 = !md_m; e_ack1 = md_m;
        end
        #1;
        chk("busy", 64'(busy), 64'(e_busy));
        chk("m0_ack", 64'(m0_ack), 64'(e_ack0));
        chk("m1_ack", 64'(m1_ack), 64'(e_ack1));
        chk("Bus_we", 64'(Bus_we), 64'(e_we));
        chk("Bus_addr", 64'(Bus_addr), 64'(e_addr));
        chk("Bus_wdata", 64'(Bus_wdata), 64'(e_wdata));
        chk("m0_rdata", 64'(m0_rdata), 64'(md_rd[0]));
        chk("m1_rdata", 64'(m1_rdata), 64'(md_rd[1]));
    end

    // Waits for the given master's ack, recording bus activity along the way.
    task automatic wait_ack(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            output int ncyc, output int we_cnt, output int we_first,
                            output int addr_hits, output int wd_hits);
        bit got = 1'b0;
        ncyc = 0; we_cnt = 0; we_first = 0; addr_hits = 0; wd_hits = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge cpu_clk);
            ncyc++;
            if (Bus_we) we_cnt++;
            if (ncyc == 1) we_first = int'(Bus_we);
            if (Bus_addr == addr) addr_hits++;
            if (Bus_wdata == wdata) wd_hits++;
            if ((m == 0) ? m0_ack : m1_ack) got = 1'b1;
        end
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL ack_timeout: master %0d got no ack, required one within 30 cycles", m);
        end
    endtask

    bit            rq [2];
    bit            rwe [2];
    logic [AW-1:0] rad [2];
    logic [DW-1:0] rwd [2];
    int            wt [2];
    int            issued [2];
    int            acked [2];

    task automatic drive_masters();
        m0_req = rq[0]; m0_we = rwe[0]; m0_addr = rad[0]; m0_wdata = rwd[0];
        m1_req = rq[1]; m1_we = rwe[1]; m1_addr = rad[1]; m1_wdata = rwd[1];
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nc, wc, wf, ah, wh, k;
        int ord [4];
        int tk [4];
        bit stopping;
        cpu_rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        Bus_rdata = '0;
        repeat (3) @(negedge cpu_clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_acks", 64'({m0_ack, m1_ack}), 64'd0);
        chk("rst_bus", 64'({Bus_we, Bus_addr}), 64'd0);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk);

        // Single read by master 0
        Bus_rdata = 32'hDEADBEEF;
        m0_we = 1'b0; m0_addr = 32'h1000; m0_wdata = 32'h1234; m0_req = 1'b1;
        wait_ack(0, 32'h1000, 32'h1234, nc, wc, wf, ah, wh);
        chk("rd_latency", 64'(nc), 64'd4);
        chk("rd_rdata", 64'(m0_rdata), 64'hDEADBEEF);
        chk("rd_no_we", 64'(wc), 64'd0);
        chk("rd_addr_cycles", 64'(ah), 64'd3);
        m0_req = 1'b0;
        @(negedge cpu_clk);

        // Write by master 1
        m1_we = 1'b1; m1_addr = 32'h2004; m1_wdata = 32'h55AA; m1_req = 1'b1;
        wait_ack(1, 32'h2004, 32'h55AA, nc, wc, wf, ah, wh);
        chk("wr_latency", 64'(nc), 64'd4);
        chk("wr_we_count", 64'(wc), 64'd1);
        chk("wr_we_first", 64'(wf), 64'd1);
        chk("wr_wdata_cycles", 64'(wh), 64'd3);
        m1_req = 1'b0;
        @(negedge cpu_clk);

        // Both requests held continuously: grants must alternate
        m0_we = 1'b0; m0_addr = 32'h3000; m1_we = 1'b0; m1_addr = 32'h4000;
        m0_req = 1'b1; m1_req = 1'b1;
        nc = 0; k = 0;
        for (int i = 0; i < 60 && k < 4; i++) begin
            @(negedge cpu_clk);
            nc++;
            if (m0_ack) begin ord[k] = 0; tk[k] = nc; k++; end
            if (m1_ack && k < 4) begin ord[k] = 1; tk[k] = nc; k++; end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("rr_count", 64'(k), 64'd4);
        chk("rr_first_time", 64'(tk[0]), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", 64'(ord[i]), 64'(i % 2));
            if (i > 0) chk("rr_spacing", 64'(tk[i] - tk[i-1]), 64'(LAT + 2));
        end
        @(negedge cpu_clk);

        // Address change after grant is ignored
        m0_addr = 32'h10; m0_req = 1'b1;
        @(negedge cpu_clk);
        chk("stab_addr0", 64'(Bus_addr), 64'h10);
        m0_addr = 32'h20;
        @(negedge cpu_clk);
        chk("stab_addr1", 64'(Bus_addr), 64'h10);
        @(negedge cpu_clk);
        chk("stab_addr2", 64'(Bus_addr), 64'h10);
        wait_ack(0, 32'h10, 32'h0, nc, wc, wf, ah, wh);
        m0_req = 1'b0;
        @(negedge cpu_clk);

        // Reset in the middle of a write
        m1_we = 1'b1; m1_addr = 32'h2004; m1_wdata = 32'h77; m1_req = 1'b1;
        @(negedge cpu_clk);
        chk("mid_we_before", 64'(Bus_we), 64'd1);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 64'(Bus_we), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_acks", 64'({m0_ack, m1_ack}), 64'd0);
        chk("mid_rst_addr", 64'(Bus_addr), 64'd0);
        m1_req = 1'b0;
        repeat (2) @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk);
        m0_we = 1'b0; m0_addr = 32'h100; m1_we = 1'b0; m1_addr = 32'h200;
        m0_req = 1'b1; m1_req = 1'b1;
        @(negedge cpu_clk);
        chk("post_rst_tie", 64'(Bus_addr), 64'h100);
        for (int i = 0; i < 40 && (m0_req || m1_req); i++) begin
            @(negedge cpu_clk);
            if (m0_ack) m0_req = 1'b0;
            if (m1_ack) m1_req = 1'b0;
        end
        chk("post_rst_drain", 64'({m0_req, m1_req}), 64'd0);

        // Randomized masters
        for (int i = 0; i < 2; i++) begin
            rq[i] = 1'b0; rwe[i] = 1'b0; rad[i] = '0; rwd[i] = '0;
            wt[i] = 0; issued[i] = 0; acked[i] = 0;
        end
        stopping = 1'b0;
        for (int cyc = 0; cyc < 4100; cyc++) begin
            @(negedge cpu_clk);
            if (cyc >= 4000) stopping = 1'b1;
            Bus_rdata = $urandom;
            for (int i = 0; i < 2; i++) begin
                if (rq[i]) begin
                    wt[i]++;
                    if ((i == 0) ? m0_ack : m1_ack) begin
                        acked[i]++;
                        n_checks++;
                        if (wt[i] > 2 * LAT + 4) begin
                            n_errors++;
                            $display("FAIL starvation: master %0d waited %0d cycles, limit %0d", i, wt[i], 2 * LAT + 4);
                        end
                        rq[i] = 1'b0;
                    end else if ($urandom_range(3) == 0) begin
                        rad[i] = $urandom; rwd[i] = $urandom;
                    end
                end
                if (!rq[i] && !stopping && $urandom_range(2) != 0) begin
                    rq[i] = 1'b1; rwe[i] = 1'($urandom_range(1));
                    rad[i] = $urandom; rwd[i] = $urandom;
                    wt[i] = 0; issued[i]++;
                end
            end
            drive_masters();
        end
        chk("rand_drained", 64'({rq[0], rq[1]}), 64'd0);
        chk("rand_m0_served", 64'(acked[0]), 64'(issued[0]));
        chk("rand_m1_served", 64'(acked[1]), 64'(issued[1]));
`ifdef ARB_PERF_CNT_EN
        chk("perf_gnt0", 64'(perf_gnt0), 64'(md_gcnt[0]));
        chk("perf_gnt1", 64'(perf_gnt1), 64'(md_gcnt[1]));
        chk("perf_conflict", 64'(perf_conflict), 64'(md_conf));
`endif
        @(negedge cpu_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter for the single Bridge data bus (Bus_addr/Bus_we/Bus_wdata/Bus_rdata).
- Master 0 is the CPU MEM stage; master 1 is a secondary master (DMA/debug loader).
- Sequences each access over a fixed-latency target with a req/ack handshake and round-robin fairness.
- The CPU stalls its pipeline while m0_req is high and m0_ack is low.

Parameters:
- RD_LAT, 1, target read latency in cycles (legal range 1..7); number of ACCESS cycles per transaction.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- cpu_clk  in  1  system clock; all state updates on rising edge.
- cpu_rst_n  in  1  reset, asynchronous, active-low.
- m0_req  in  1  master 0 request; held high until m0_ack.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_rdata  out  DW  master 0 read data; valid when m0_ack=1.
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same widths and meanings for master 1.
- Bus_addr  out  AW  address to Bridge.
- Bus_we  out  1  write strobe to Bridge.
- Bus_wdata  out  DW  write data to Bridge.
- Bus_rdata  in  DW  read data from Bridge.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, cpu_rst_n=0):
  - state=IDLE, last_gnt=1 (so master 0 wins the first tie), lat_cnt=0.
  - Outputs: m0_ack, m1_ack, Bus_we and busy = 0; Bus_addr, Bus_wdata, m0_rdata and m1_rdata = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On a rising edge with any req high, latch the winner into gnt, and latch its we/addr/wdata into internal registers.
  - Set lat_cnt=RD_LAT-1 and go to ACCESS.
  - No request: stay in IDLE.
- Arbitration:
  - Only one request: that master wins.
  - Both requests: the master != last_gnt wins.
  - last_gnt updates to gnt on entry to ACCESS.
- ACCESS:
  - Bus_addr and Bus_wdata are driven from the latched registers for every ACCESS cycle.
  - Bus_we = latched we during the first ACCESS cycle only (single write strobe per transaction).
  - lat_cnt decrements each cycle; at lat_cnt==0, capture Bus_rdata into the granted master's rdata register and go to RESP.
  - Writes also spend RD_LAT cycles in ACCESS, giving uniform timing.
- RESP:
  - Granted master's ack=1 for exactly this cycle; rdata holds its value until the next capture for that master.
  - Next state is always IDLE.
  - A master must drop or renew req on the cycle after ack. Req sampled high during RESP is ignored; it is arbitrated in the following IDLE.
- Latency: req high at edge N gives ack high during cycle N+RD_LAT+1. Minimum request-to-request period is RD_LAT+2 cycles.
- Outside ACCESS: Bus_addr, Bus_wdata and Bus_we are 0.
- Master behaviour:
  - Changes to the granted master's addr/wdata after grant are ignored (latched).
  - A non-granted master's req stays pending without loss.
- Reset mid-transaction: immediate abort to reset values. No ack is issued, no further Bus_we.
- Counters do not wrap beyond their range; lat_cnt is 3 bits.
- The non-granted ack is always 0; m0_ack and m1_ack are never high together.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_gnt0[31:0], perf_gnt1[31:0] and perf_conflict[31:0], all reset to 0.
  - perf_gnt0 and perf_gnt1 increment on each ACCESS entry for master 0 and master 1 respectively.
  - perf_conflict increments each cycle where m0_req, m1_req and state!=IDLE are all true, or both requests are high in IDLE.
  - All three wrap at 2^32.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then single read: RD_LAT=1, m0_req=1, m0_we=0, m0_addr=0x1000, Bus_rdata=0xDEADBEEF → Bus_addr=0x1000 for 1 cycle, m0_ack pulse 2 cycles after req sampled, m0_rdata=0xDEADBEEF, Bus_we never 1.
- Write: m1 writes 0x55AA to 0x2004, RD_LAT=3 → Bus_we=1 only in the first of 3 ACCESS cycles, Bus_wdata=0x55AA throughout, m1_ack 4 cycles after sample.
- Simultaneous requests held continuously → grants alternate m0, m1, m0, m1; each ack arrives RD_LAT+2 cycles apart; no lost request.
- Stability: master 0 changes m0_addr from 0x10 to 0x20 mid-ACCESS → Bus_addr stays 0x10.
- Reset mid-op: assert cpu_rst_n=0 during ACCESS with a write → Bus_we=0, busy=0 and acks 0 immediately; after release, m0 wins the first tie.
- ARB_PERF_CNT_EN: 3 m0 and 2 m1 transactions → perf_gnt0=3, perf_gnt1=2.
